// File: rtl/iob_logic_reduce_pkg.sv
// Shared op codes, FSM state type and identity helper for the streaming logic reducer.
package iob_logic_reduce_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    // Widest lane the identity helper covers; callers truncate to their own W.
    localparam int unsigned ID_W = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Fold identity: all-ones for AND/NAND, zero for OR/XOR.
    function automatic logic [ID_W-1:0] op_identity(input logic [1:0] op);
        op_identity = ((op == OP_AND) || (op == OP_NAND)) ? {ID_W{1'b1}} : {ID_W{1'b0}};
    endfunction

endpackage

// File: rtl/iob_logic_reduce_lanes.sv
// Combinational fold of N W-bit lanes with the selected bitwise op (NAND folds as AND).
module iob_logic_reduce_lanes
    import iob_logic_reduce_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 2
) (
    input  logic [N*W-1:0] data_i,
    input  logic [1:0]     op_i,
    output logic [W-1:0]   f_o
);

    always_comb begin
        f_o = W'(op_identity(op_i));
        for (int unsigned k = 0; k < N; k++) begin
            case (op_i)
                OP_OR:   f_o = f_o | data_i[k*W +: W];
                OP_XOR:  f_o = f_o ^ data_i[k*W +: W];
                default: f_o = f_o & data_i[k*W +: W];
            endcase
        end
    end

endmodule

// File: rtl/iob_logic_reduce_acc.sv
// Streaming lane reducer: folds each beat, accumulates across a packet, publishes one
// registered result with a saturating beat count per packet over valid/ready.
module iob_logic_reduce_acc
    import iob_logic_reduce_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             arst_n_i,
    input  logic [1:0]       op_i,
    input  logic [N*W-1:0]   data_i,
    input  logic             last_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [W-1:0]     result_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q;
    logic [1:0]       op_q;
    logic [W-1:0]     acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic [W-1:0]     result_q;
    logic [CNT_W-1:0] count_q;
    logic             sat_out_q;
    logic             valid_q;

    logic [1:0]       op_eff;
    logic [W-1:0]     fold;
    logic [W-1:0]     acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_d;
    logic             in_hs;
    logic             out_hs;

    assign ready_o = ~valid_q | ready_i;
    assign in_hs   = valid_i & ready_o & cke_i;
    assign out_hs  = valid_q & ready_i & cke_i;

    // The op is latched on the first beat; later beats reuse it regardless of op_i.
    assign op_eff = (state_q == ST_IDLE) ? op_i : op_q;

    iob_logic_reduce_lanes #(
        .W (W),
        .N (N)
    ) u_lanes (
        .data_i (data_i),
        .op_i   (op_eff),
        .f_o    (fold)
    );

    // Accumulator and counter values that the current beat would produce.
    always_comb begin
        acc_d = fold;
        cnt_d = CNT_W'(1);
        sat_d = 1'b0;
        if (state_q == ST_ACCUM) begin
            case (op_q)
                OP_OR:   acc_d = acc_q | fold;
                OP_XOR:  acc_d = acc_q ^ fold;
                default: acc_d = acc_q & fold;
            endcase
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sat_d = sat_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_AND;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            result_q  <= '0;
            count_q   <= '0;
            sat_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (out_hs) begin
                valid_q <= 1'b0;
            end
            if (in_hs) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                sat_q <= sat_d;
                if (state_q == ST_IDLE) begin
                    op_q <= op_i;
                end
                // A publish on the consume edge keeps valid high for full-rate streaming.
                if (last_i) begin
                    state_q   <= ST_IDLE;
                    result_q  <= (op_eff == OP_NAND) ? ~acc_d : acc_d;
                    count_q   <= cnt_d;
                    sat_out_q <= sat_d;
                    valid_q   <= 1'b1;
                end else begin
                    state_q <= ST_ACCUM;
                end
            end
        end
    end

    assign result_o = result_q;
    assign count_o  = count_q;
    assign sat_o    = sat_out_q;
    assign valid_o  = valid_q;

endmodule
